// File: rtl/data_memory_arbiter.sv
`timescale 1ns/1ps
// data_memory_arbiter
// Shares one single-port data memory between port 0 (CPU load/store, high
// priority) and port 1 (DMA/debug, low priority, anti-starvation boost).
// Locked sequences keep ownership with one port for atomic read-modify-write.
//
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_mN_req/we/addr/wrMask/wrData/lock   requester N access fields
//   o_mN_ack                   access accepted this cycle (combinational)
//   o_mN_rdData, o_mN_rdValid  registered read data and one-cycle valid pulse
//   o_mem_addr/wrEnable/wrMask/wrData     drive to the memory
//   i_mem_rdData               combinational memory read data
module data_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_m0_req,
  input  logic                    i_m0_we,
  input  logic [ADDR_WIDTH-1:0]   i_m0_addr,
  input  logic [DATA_WIDTH/8-1:0] i_m0_wrMask,
  input  logic [DATA_WIDTH-1:0]   i_m0_wrData,
  input  logic                    i_m0_lock,
  output logic                    o_m0_ack,
  output logic [DATA_WIDTH-1:0]   o_m0_rdData,
  output logic                    o_m0_rdValid,
  input  logic                    i_m1_req,
  input  logic                    i_m1_we,
  input  logic [ADDR_WIDTH-1:0]   i_m1_addr,
  input  logic [DATA_WIDTH/8-1:0] i_m1_wrMask,
  input  logic [DATA_WIDTH-1:0]   i_m1_wrData,
  input  logic                    i_m1_lock,
  output logic                    o_m1_ack,
  output logic [DATA_WIDTH-1:0]   o_m1_rdData,
  output logic                    o_m1_rdValid,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_wrEnable,
  output logic [DATA_WIDTH/8-1:0] o_mem_wrMask,
  output logic [DATA_WIDTH-1:0]   o_mem_wrData,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdData
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic                    gnt0_s, gnt1_s;
  logic                    ack0_s, ack1_s;
  logic [DATA_WIDTH-1:0]   rd_data0_q, rd_data1_q;
  logic                    rd_valid0_q, rd_valid1_q;

  // Grant selection from the lock state, the requests and the starve counter.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_q)
      ST_FREE: begin
        // Port 1 wins when alone or once it has waited STARVE_LIMIT cycles.
        if (i_m1_req && (!i_m0_req || (starve_q >= LIMIT_C))) begin
          gnt1_s = 1'b1;
        end else if (i_m0_req) begin
          gnt0_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      ST_LOCK0: gnt0_s = i_m0_req;
      ST_LOCK1: gnt1_s = i_m1_req;
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  // Acks are suppressed during reset so no memory write can slip through.
  assign ack0_s   = gnt0_s & i_m0_req & ~i_reset;
  assign ack1_s   = gnt1_s & i_m1_req & ~i_reset;
  assign o_m0_ack = ack0_s;
  assign o_m1_ack = ack1_s;

  // Lock-state next-state and saturating starve counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FREE: begin
        if (ack0_s && i_m0_lock) begin
          state_d = ST_LOCK0;
        end else if (ack1_s && i_m1_lock) begin
          state_d = ST_LOCK1;
        end else begin
          state_d = ST_FREE;
        end
      end
      ST_LOCK0: begin
        // Owner releases explicitly or abandons by dropping its request.
        if (!i_m0_req || (ack0_s && !i_m0_lock)) begin
          state_d = ST_FREE;
        end else begin
          state_d = ST_LOCK0;
        end
      end
      ST_LOCK1: begin
        if (!i_m1_req || (ack1_s && !i_m1_lock)) begin
          state_d = ST_FREE;
        end else begin
          state_d = ST_LOCK1;
        end
      end
      default: state_d = ST_FREE;
    endcase

    if (i_m1_req && !ack1_s) begin
      starve_d = (starve_q >= LIMIT_C) ? LIMIT_C : (starve_q + 4'd1);
    end else begin
      starve_d = 4'd0;
    end
  end

  // Memory drive: granted port's fields, port 0's fields when idle.
  always_comb begin
    if (gnt1_s) begin
      o_mem_addr   = i_m1_addr;
      o_mem_wrMask = i_m1_wrMask;
      o_mem_wrData = i_m1_wrData;
    end else begin
      o_mem_addr   = i_m0_addr;
      o_mem_wrMask = i_m0_wrMask;
      o_mem_wrData = i_m0_wrData;
    end
    o_mem_wrEnable = (ack0_s & i_m0_we) | (ack1_s & i_m1_we);
  end

  // State, counter and read-return registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_FREE;
      starve_q    <= 4'd0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      rd_valid0_q <= ack0_s & ~i_m0_we;
      rd_valid1_q <= ack1_s & ~i_m1_we;
      if (ack0_s && !i_m0_we) begin
        rd_data0_q <= i_mem_rdData;
      end
      if (ack1_s && !i_m1_we) begin
        rd_data1_q <= i_mem_rdData;
      end
    end
  end

  // A reset arriving right after an acked read cancels the pending pulse.
  assign o_m0_rdValid = rd_valid0_q & ~i_reset;
  assign o_m1_rdValid = rd_valid1_q & ~i_reset;
  assign o_m0_rdData  = rd_data0_q;
  assign o_m1_rdData  = rd_data1_q;

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares one single-port data memory slave between two requesters: port 0 (CPU load/store unit, high priority) and port 1 (DMA/debug port, low priority).
- Port 0 has fixed priority. Port 1 gets a bounded-latency anti-starvation boost.
- Supports locked sequences for atomic read-modify-write.
- Sits between the requesters and the data memory. The memory has a combinational read and commits writes on the clock edge.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits. Must be a multiple of 8.
- STARVE_LIMIT, 4, number of consecutive denied cycles of port 1 after which port 1 outranks port 0. Range 1..15.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_mN_req  in  1  port N (N=0,1) access request.
- i_mN_we  in  1  1 = write, 0 = read.
- i_mN_addr  in  ADDR_WIDTH  byte address.
- i_mN_wrMask  in  DATA_WIDTH/8  byte write enables.
- i_mN_wrData  in  DATA_WIDTH  write data.
- i_mN_lock  in  1  keep ownership after this access.
- o_mN_ack  out  1  access accepted this cycle (combinational).
- o_mN_rdData  out  DATA_WIDTH  registered read data.
- o_mN_rdValid  out  1  o_mN_rdData valid, one-cycle pulse.
- o_mem_addr  out  ADDR_WIDTH  to memory.
- o_mem_wrEnable  out  1  to memory.
- o_mem_wrMask  out  DATA_WIDTH/8  to memory.
- o_mem_wrData  out  DATA_WIDTH  to memory.
- i_mem_rdData  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset:
  - State = FREE, starve counter = 0.
  - o_mN_rdValid = 0, o_mN_rdData = 0.
  - o_mem_wrEnable = 0 during the reset cycle. Acks are forced to 0 while i_reset = 1.
  - A reset mid-lock drops the lock. A pending rdValid is cancelled.
- Grant (combinational, from current state and requests):
  - FREE: grant port 1 if i_m1_req and (not i_m0_req, or counter >= STARVE_LIMIT). Otherwise grant port 0 if i_m0_req.
  - LOCK0: only port 0 can be granted. Port 1 is denied.
  - LOCK1: only port 1 can be granted. Port 0 is denied.
- Acknowledge: o_mN_ack = granted and i_mN_req. At most one ack per cycle. An acked access completes in that cycle; there are no wait states.
- Memory drive:
  - The o_mem_* outputs carry the granted port's fields.
  - o_mem_wrEnable = ack and we.
  - With no grant, o_mem_wrEnable = 0, and addr, mask and data are driven from port 0 (don't-care).
- Read: on an acked read, the edge captures i_mem_rdData into o_mN_rdData. o_mN_rdValid = 1 for exactly the next cycle. Read latency is 1 cycle.
- Write: the write commits on the ack edge. No rdValid is produced.
- rdData holds its value between reads.
- Lock state transitions (at the edge):
  - FREE -> LOCKn on an acked access from port n with i_mn_lock = 1.
  - LOCKn -> FREE on an acked access from port n with lock = 0, or on any cycle where i_mn_req = 0 (owner abandons).
  - LOCKn stays LOCKn on an acked access from port n with lock = 1.
- Starve counter (4-bit, saturating at STARVE_LIMIT):
  - Increments each cycle i_m1_req = 1 and o_m1_ack = 0.
  - Clears on o_m1_ack or i_m1_req = 0.
  - It still counts in LOCK0, but the boost takes effect only once the state returns to FREE.
- Simultaneous events:
  - Both ports request and counter < STARVE_LIMIT: port 0 wins.
  - Both request and counter = STARVE_LIMIT: port 1 wins and the counter clears.
- A read and a write in consecutive cycles from different ports are independent. Each port's rdValid is separate.

Test Plan:
- Reset, then port 0 reads 0x100 with memory word 0xDEADBEEF -> o_m0_ack = 1 in cycle 0; cycle 1 o_m0_rdValid = 1 and o_m0_rdData = 0xDEADBEEF; o_m1_rdValid stays 0.
- Port 0 writes 0x11223344 to 0x40 with mask 4'b0011 while port 1 idles -> o_mem_wrEnable = 1 with mask 0011 in one cycle; a port 1 read of 0x40 (prior 0xAAAAAAAA) then returns 0xAAAA3344.
- Both ports request continuously with STARVE_LIMIT = 4 -> port 0 is acked 4 cycles, port 1 is acked in cycle 4, port 0 in cycles 5..8, port 1 in cycle 9 (repeating 4:1 pattern).
- Port 1 does a locked read of 0x80 then an unlocked write of 0x80, while port 0 requests throughout -> port 0 is denied both cycles; port 0 is acked in the cycle after the unlocked write.
- Port 0 asserts a lock, then drops i_m0_req for one cycle while port 1 requests -> state returns to FREE; port 1 is acked the following cycle.
- i_reset asserted in the cycle after an acked read while in LOCK1 -> o_m1_rdValid = 0; the state is FREE after reset; the next port 0 request is acked immediately.
